// File: rtl/irq_trap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_trap_ctrl: mip/mie CSRs, interrupt priority, trap req/ack FSM |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module irq_trap_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [11:0] MIE_ADDR = 12'h304,
  parameter logic [11:0] MIP_ADDR = 12'h344
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tip,
  input  logic            i_sip,
  input  logic            i_eip,
  input  logic            i_gie,
  input  logic            i_csr_wen,
  input  logic            i_csr_ren,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wrdata,
  output logic [XLEN-1:0] o_csr_rddata,
  output logic            o_irq_req,
  output logic [XLEN-1:0] o_irq_cause,
  input  logic            i_irq_ack,
  input  logic            i_mret
);

  localparam logic [XLEN-1:0] c_irq_mask = {{(XLEN-12){1'b0}}, 12'h888};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    TAKEN = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_eip_meta;
  logic            r_eip_sync;
  logic            r_tip;
  logic            r_sip;
  logic [XLEN-1:0] r_mie;
  logic [2:0]      r_sel;

  logic [XLEN-1:0] w_mip;
  logic            w_mei;
  logic            w_mti;
  logic            w_msi;
  logic [2:0]      w_pend;
  logic [2:0]      w_sel;
  logic [3:0]      w_code;
  logic [XLEN-1:0] w_new_cause;

  // Interrupt sources; the external line is asynchronous and needs a 2-flop sync
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_eip_meta <= 1'b0;
      r_eip_sync <= 1'b0;
      r_tip      <= 1'b0;
      r_sip      <= 1'b0;
      r_mie      <= '0;
    end else begin
      r_eip_meta <= i_eip;
      r_eip_sync <= r_eip_meta;
      r_tip      <= i_tip;
      r_sip      <= i_sip;
      if (i_csr_wen && (i_csr_addr == MIE_ADDR))
        r_mie <= i_csr_wrdata & c_irq_mask;
    end
  end

  always_comb begin
    w_mip     = '0;
    w_mip[11] = r_eip_sync;
    w_mip[7]  = r_tip;
    w_mip[3]  = r_sip;
  end

  assign w_mei  = r_eip_sync & r_mie[11];
  assign w_mti  = r_tip & r_mie[7];
  assign w_msi  = r_sip & r_mie[3];
  assign w_pend = {w_mei, w_mti, w_msi};

  // Fixed priority MEI > MSI > MTI; w_sel is one-hot over {mei, mti, msi}
  always_comb begin
    w_sel  = 3'b000;
    w_code = 4'd0;
    if (w_mei) begin
      w_sel  = 3'b100;
      w_code = 4'd11;
    end else if (w_msi) begin
      w_sel  = 3'b001;
      w_code = 4'd3;
    end else if (w_mti) begin
      w_sel  = 3'b010;
      w_code = 4'd7;
    end
  end

  assign w_new_cause = {1'b1, {(XLEN-5){1'b0}}, w_code};

  always_comb begin
    o_csr_rddata = '0;
    if (i_csr_ren) begin
      if (i_csr_addr == MIE_ADDR)
        o_csr_rddata = r_mie;
      else if (i_csr_addr == MIP_ADDR)
        o_csr_rddata = w_mip;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_sel       <= 3'b000;
      o_irq_req   <= 1'b0;
      o_irq_cause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_gie && (|w_pend)) begin
            r_state     <= REQ;
            r_sel       <= w_sel;
            o_irq_req   <= 1'b1;
            o_irq_cause <= w_new_cause;
          end
        end
        REQ: begin
          // Ack takes precedence over a simultaneous withdraw
          if (i_irq_ack) begin
            r_state   <= TAKEN;
            o_irq_req <= 1'b0;
          end else if (!i_gie || !(|(r_sel & w_pend))) begin
            r_state   <= IDLE;
            o_irq_req <= 1'b0;
          end
        end
        TAKEN: begin
          if (i_mret)
            r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          o_irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_trap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_irq_trap_ctrl: directed + random bench with behavioural model  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tip = 1'b0, sip = 1'b0, eip = 1'b0, gie = 1'b0;
  logic        wen = 1'b0, ren = 1'b0, ack = 1'b0, mret = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [31:0] wrdata = 32'h0;
  logic [31:0] rddata, cause;
  logic        req;

  int errors = 0;
  int checks = 0;

  // Model state: what the interrupt controller has promised the core
  logic [31:0] m_mie = 0;
  logic        m_tip = 0, m_sip = 0;
  logic        m_eip_hist [2] = '{1'b0, 1'b0};
  logic        m_req = 0, m_in_handler = 0;
  int          m_code = 0;
  logic [31:0] m_cause = 0;

  always #5 clk = ~clk;

  irq_trap_ctrl #(.XLEN(32), .MIE_ADDR(12'h304), .MIP_ADDR(12'h344)) dut (
    .i_clk(clk), .i_rst(rst), .i_tip(tip), .i_sip(sip), .i_eip(eip), .i_gie(gie),
    .i_csr_wen(wen), .i_csr_ren(ren), .i_csr_addr(addr), .i_csr_wrdata(wrdata),
    .o_csr_rddata(rddata), .o_irq_req(req), .o_irq_cause(cause),
    .i_irq_ack(ack), .i_mret(mret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (32'(m_eip_hist[1]) << 11) | (32'(m_tip) << 7) | (32'(m_sip) << 3);
  endfunction

  function automatic logic [31:0] m_rd();
    if (!ren) return 32'h0;
    if (addr == 12'h304) return m_mie;
    if (addr == 12'h344) return m_mip();
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] pend;
    pend = m_mip() & m_mie;
    if (!rst) begin
      m_req = 0; m_in_handler = 0; m_cause = 0; m_mie = 0;
      m_tip = 0; m_sip = 0; m_eip_hist[0] = 0; m_eip_hist[1] = 0;
    end else begin
      if (m_in_handler) begin
        if (mret) m_in_handler = 0;
      end else if (m_req) begin
        if (ack) begin
          m_req = 0; m_in_handler = 1;
        end else if (!gie || !pend[m_code]) begin
          m_req = 0;
        end
      end else if (gie && pend != 0) begin
        m_req   = 1;
        m_code  = pend[11] ? 11 : (pend[3] ? 3 : 7);
        m_cause = 32'h8000_0000 | 32'(m_code);
      end
      if (wen && addr == 12'h304) m_mie = wrdata & 32'h888;
      m_eip_hist[1] = m_eip_hist[0];
      m_eip_hist[0] = eip;
      m_tip = tip;
      m_sip = sip;
    end
  endtask

  // One clock: check combinational read, advance model, check registered outputs
  task automatic cycle();
    #1 chk("rddata", rddata, m_rd());
    @(posedge clk);
    model_edge();
    #1;
    chk("req", 32'(req), 32'(m_req));
    if (m_req) chk("cause", cause, m_cause);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    wen = 1; addr = a; wrdata = d;
    cycle();
    wen = 0;
  endtask

  task automatic csr_read(input string name, input logic [11:0] a, input logic [31:0] exp);
    ren = 1; addr = a;
    #1 chk(name, rddata, exp);
    ren = 0;
  endtask

  initial begin
    // Reset state
    cycles(2);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_cause", cause, 32'h0);
    csr_read("rst_mie", 12'h304, 32'h0);
    csr_read("rst_mip", 12'h344, 32'h0);
    rst = 1; gie = 1;

    // Timer latency
    csr_write(12'h304, 32'h80);
    tip = 1;
    cycle();
    csr_read("t1_mip", 12'h344, 32'h80);
    chk("t1_req_early", 32'(req), 32'h0);
    cycle();
    chk("t1_req", 32'(req), 32'h1);
    chk("t1_cause", cause, 32'h8000_0007);
    ack = 1; tip = 0; cycle(); ack = 0;
    mret = 1; cycle(); mret = 0;
    cycles(2);
    chk("t1_idle", 32'(req), 32'h0);

    // Priority, then re-request after mret
    csr_write(12'h304, 32'h0);
    tip = 1; sip = 1; eip = 1;
    cycles(3);
    csr_write(12'h304, 32'h888);
    chk("t2_req_early", 32'(req), 32'h0);
    cycle();
    chk("t2_req", 32'(req), 32'h1);
    chk("t2_cause_mei", cause, 32'h8000_000B);
    ack = 1; cycle(); ack = 0;
    eip = 0; cycles(3);
    chk("t2_taken", 32'(req), 32'h0);
    mret = 1; cycle(); mret = 0;
    chk("t2_mret_gap", 32'(req), 32'h0);
    cycle();
    chk("t2_req2", 32'(req), 32'h1);
    chk("t2_cause_msi", cause, 32'h8000_0003);
    ack = 1; tip = 0; sip = 0; cycle(); ack = 0;
    cycles(2); mret = 1; cycle(); mret = 0; cycles(2);

    // Withdraw, and ack on the withdraw cycle
    tip = 1;
    csr_write(12'h304, 32'h80);
    cycle();
    chk("t3_req", 32'(req), 32'h1);
    tip = 0; cycle();
    chk("t3_hold", 32'(req), 32'h1);
    cycle();
    chk("t3_withdraw", 32'(req), 32'h0);
    tip = 1; cycles(2);
    chk("t3_req2", 32'(req), 32'h1);
    tip = 0; cycle();
    ack = 1; cycle(); ack = 0;
    chk("t3_ack_wins", 32'(req), 32'h0);
    tip = 1; cycles(3);
    chk("t3_taken_ignores", 32'(req), 32'h0);
    mret = 1; cycle(); mret = 0;
    chk("t6_gap", 32'(req), 32'h0);
    cycle();
    chk("t6_req", 32'(req), 32'h1);
    chk("t6_cause", cause, 32'h8000_0007);
    ack = 1; tip = 0; cycle(); ack = 0;
    cycle(); mret = 1; cycle(); mret = 0; cycles(2);

    // CSR write masking / read-only mip
    gie = 0; tip = 1; cycles(2);
    csr_read("t4_mip_before", 12'h344, 32'h80);
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read("t4_mie", 12'h304, 32'h888);
    csr_read("t4_mip_after", 12'h344, 32'h80);

    // Global enable gating, reset while requesting
    cycles(3);
    chk("t5_gie_off", 32'(req), 32'h0);
    gie = 1; cycle();
    chk("t5_req", 32'(req), 32'h1);
    chk("t5_cause", cause, 32'h8000_0007);
    rst = 0; cycle();
    chk("t5_rst_req", 32'(req), 32'h0);
    chk("t5_rst_cause", cause, 32'h0);
    csr_read("t5_rst_mie", 12'h304, 32'h0);
    rst = 1; tip = 0;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) tip = ~tip;
      if ($urandom_range(0, 9) == 0) sip = ~sip;
      if ($urandom_range(0, 9) == 0) eip = ~eip;
      gie  = ($urandom_range(0, 7) != 0);
      wen  = ($urandom_range(0, 7) == 0);
      ren  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: addr = 12'h304;
        1: addr = 12'h344;
        2: addr = 12'h300;
        default: addr = 12'($urandom);
      endcase
      wrdata = $urandom;
      ack  = ($urandom_range(0, 2) == 0);
      mret = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
